// File: rtl/regfile_write_arbiter.sv
// Shares the 8x16 register file write port between three requesters with a registered commit stage.
// Define REGARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            hold,
    input  logic [NREQ-1:0] req_valid,
    input  logic [2:0]      req_dr0,
    input  logic [2:0]      req_dr1,
    input  logic [2:0]      req_dr2,
    input  logic [DW-1:0]   req_data0,
    input  logic [DW-1:0]   req_data1,
    input  logic [DW-1:0]   req_data2,
    output logic [NREQ-1:0] req_ready,
    output logic            wr_en,
    output logic [2:0]      wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [7:0]      busy_mask,
    output logic [1:0]      last_grant,
    output logic [15:0]     wr_count
);

    logic [NREQ-1:0] grant_p0;
    logic            xfer_p0;
    logic [1:0]      idx_p0;
    logic [2:0]      sel_dr_p0;
    logic [DW-1:0]   sel_data_p0;

    function automatic logic [NREQ-1:0] pick_fixed(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] g;
        g = '0;
        if (v[0])      g = 3'b001;
        else if (v[1]) g = 3'b010;
        else if (v[2]) g = 3'b100;
        return g;
    endfunction

`ifdef REGARB_ROUND_ROBIN_EN
    // Search starts one past the last winner, so the last winner has lowest priority.
    function automatic logic [NREQ-1:0] pick_rr(input logic [NREQ-1:0] v, input logic [1:0] lg);
        logic [NREQ-1:0] g;
        g = '0;
        case (lg)
            2'd0: begin
                if (v[1])      g = 3'b010;
                else if (v[2]) g = 3'b100;
                else if (v[0]) g = 3'b001;
            end
            2'd1: begin
                if (v[2])      g = 3'b100;
                else if (v[0]) g = 3'b001;
                else if (v[1]) g = 3'b010;
            end
            default: g = pick_fixed(v);
        endcase
        return g;
    endfunction
`endif

    // Stage p0: combinational grant and winner select
    always_comb begin
        grant_p0 = '0;
        if (!Reset && !hold) begin
`ifdef REGARB_ROUND_ROBIN_EN
            grant_p0 = pick_rr(req_valid, last_grant);
`else
            grant_p0 = pick_fixed(req_valid);
`endif
        end
    end

    assign req_ready = grant_p0;
    assign xfer_p0   = |grant_p0;

    always_comb begin
        idx_p0      = 2'd0;
        sel_dr_p0   = req_dr0;
        sel_data_p0 = req_data0;
        case (grant_p0)
            3'b010: begin
                idx_p0      = 2'd1;
                sel_dr_p0   = req_dr1;
                sel_data_p0 = req_data1;
            end
            3'b100: begin
                idx_p0      = 2'd2;
                sel_dr_p0   = req_dr2;
                sel_data_p0 = req_data2;
            end
            default: ;
        endcase
    end

    // Stage p1: registered commit toward the register file
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= 3'd0;
            wr_data    <= '0;
            last_grant <= 2'd2;
            wr_count   <= 16'd0;
        end else begin
            wr_en <= xfer_p0;
            if (xfer_p0) begin
                wr_addr    <= sel_dr_p0;
                wr_data    <= sel_data_p0;
                last_grant <= idx_p0;
            end
            if (wr_en)
                wr_count <= wr_count + 16'd1;
        end
    end

    always_comb begin
        busy_mask = 8'h00;
        if (wr_en)
            busy_mask[wr_addr] = 1'b1;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 8x16 register file between three requesters: the main control datapath (requester 0), the thread-increment unit that updates R0/R1 (requester 1), and the host/loader path (requester 2). Each requester presents a destination register and 16-bit data under a valid/ready handshake. The arbiter grants at most one request per cycle and drives a registered write strobe, address and data into the register file's load-enable, destination-select and bus inputs. It also keeps a grant pointer and a commit counter for debug.

## Interface
Parameters:
- NREQ, 3, number of requesters; fixed at 3, other values unsupported.
- DW, 16, data width.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- hold  in  1  when 1, no grants are issued; in-flight commit still completes.
- req_valid  in  3  bit i set = requester i presents a write.
- req_dr0 / req_dr1 / req_dr2  in  3 each  destination register index of requester i.
- req_data0 / req_data1 / req_data2  in  16 each  write data of requester i.
- req_ready  out  3  one-hot or zero; bit i = requester i granted this cycle.
- wr_en  out  1  register-file load strobe (registered).
- wr_addr  out  3  register-file destination index (registered).
- wr_data  out  16  register-file write data (registered).
- busy_mask  out  8  one-hot of wr_addr while wr_en=1, else 0.
- last_grant  out  2  index of the most recently granted requester.
- wr_count  out  16  number of commits since reset, wraps.

## Operation
- A transfer occurs for requester i in a cycle where req_valid[i] && req_ready[i] are both 1 at the rising edge.
- req_ready is combinational from req_valid, hold and last_grant.
- req_ready never asserts for a requester whose valid is 0, and at most one bit is set per cycle.
- Requesters hold valid, dr and data stable until granted; dropping valid before grant is legal and simply withdraws the request.
- Arbitration order, round-robin: search starts at (last_grant+1) mod 3 and wraps. The requester granted last has lowest priority next cycle.
- last_grant updates only on a transfer; idle cycles leave it unchanged.
- Commit: on a transfer, the next edge loads wr_en=1, wr_addr=req_drN and wr_data=req_dataN of the winner. With no transfer, wr_en=0 and wr_addr/wr_data hold their previous values.
- wr_count increments by 1 on every cycle wr_en is registered as 1. 0xFFFF+1 wraps to 0x0000.
- Two requesters targeting the same register in the same cycle: only the winner commits; the loser is serviced in a later cycle, so its data lands last.
- hold=1: req_ready=0. A commit registered in the previous cycle still appears on wr_en. last_grant is unchanged.
- last_grant index 3 is never produced.

## Timing
- Reset values: req_ready=0 (during reset), wr_en=0, wr_addr=0, wr_data=0x0000, busy_mask=0x00, last_grant=2 (so requester 0 wins first), wr_count=0x0000.
- Latency: grant in cycle N, register-file write strobe in cycle N+1, new value readable from the register file in cycle N+2.
- Throughput: one commit per cycle; back-to-back grants to different or the same requester are allowed.
- Reset mid-operation: a registered but not-yet-consumed commit is discarded, and wr_en drops immediately (asynchronously).
- Reset does not drive req_ready low asynchronously beyond combinational gating. req_ready is forced 0 while Reset=1.

## Configuration
- REGARB_ROUND_ROBIN_EN defined: round-robin arbitration as above.
- REGARB_ROUND_ROBIN_EN undefined: fixed priority 0 > 1 > 2. last_grant is still tracked and output but does not affect arbitration. All other behaviour is identical.

## Test plan
- Reset, then req_valid=001, dr0=3, data0=0x1234 -> req_ready=001 in cycle 0; cycle 1 wr_en=1, wr_addr=3, wr_data=0x1234, busy_mask=0x08, wr_count=1 in cycle 2.
- Round-robin build: req_valid=111 held for 6 cycles, all with distinct data -> grant sequence 0,1,2,0,1,2 and six back-to-back wr_en pulses. Fixed-priority build: grant 0 every cycle.
- Same-target conflict: req 0 dr=1 data=0xAAAA and req 1 dr=1 data=0x5555 together, round-robin from reset -> 0xAAAA commits first, then 0x5555; R1 ends as 0x5555.
- hold=1 with req_valid=110 for 3 cycles -> req_ready=000 and wr_en=0. On hold=0 -> requester 1 granted first, then 2.
- Reset asserted the cycle after a grant -> wr_en=0 and wr_count=0 without waiting for a clock edge. After release, last_grant=2.
- wr_count wrap: drive 65536 consecutive commits -> wr_count returns to 0x0000 while wr_en stays 1 every cycle.
